// File: rtl/ring_phase_monitor.sv
// Watches a one-hot ring counter word, decodes its phase, verifies the rotation
// sequence, locks after a run of correct steps and counts revolutions while locked.
module ring_phase_monitor #(
    parameter int WIDTH      = 4,
    parameter int PH_W       = 2,
    parameter int REV_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int DIR        = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_q,
    input  logic             ring_valid,
    input  logic             err_clr,
    output logic [PH_W-1:0]  phase,
    output logic             phase_valid,
    output logic             locked,
    output logic [REV_W-1:0] revs,
    output logic             err_pulse,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [3:0]       LOCK_CNT = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             locked_q, locked_d;
    logic [REV_W-1:0] revs_q, revs_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;

    logic             onehot;
    logic             good;
    logic             wrap;
    logic             fault;
    logic [WIDTH-1:0] exp_word;
    logic [PH_W-1:0]  hot_idx;
    logic [3:0]       cnt_inc;

    // Expected word is the previous sample stepped once in the configured direction.
    assign exp_word = (DIR == 0) ? {prev_q[WIDTH-2:0], prev_q[WIDTH-1]}
                                 : {prev_q[0], prev_q[WIDTH-1:1]};
    assign onehot   = (ring_q != '0) && ((ring_q & (ring_q - ONE_W)) == '0);
    assign good     = onehot && (ring_q == exp_word);
    assign wrap     = (DIR == 0) ? (prev_q[WIDTH-1] && ring_q[0])
                                 : (prev_q[0] && ring_q[WIDTH-1]);
    assign cnt_inc  = match_cnt_q + 4'd1;

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_q[i]) begin
                hot_idx = PH_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        match_cnt_d   = match_cnt_q;
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        locked_d      = locked_q;
        revs_d        = revs_q;
        err_pulse_d   = 1'b0;
        fault         = 1'b0;

        if (ring_valid) begin
            prev_d        = ring_q;
            phase_valid_d = onehot;
            if (onehot) begin
                phase_d = hot_idx;
            end

            unique case (state_q)
                IDLE: begin
                    if (onehot) begin
                        state_d     = ACQUIRE;
                        match_cnt_d = 4'd0;
                    end
                end
                ACQUIRE: begin
                    if (good) begin
                        match_cnt_d = cnt_inc;
                        if (cnt_inc == LOCK_CNT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (onehot) begin
                        match_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        if (wrap) begin
                            revs_d = revs_q + REV_W'(1);
                        end
                    end else begin
                        fault       = 1'b1;
                        err_pulse_d = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = 4'd0;
                        state_d     = onehot ? ACQUIRE : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A fault on the same edge as a clear request keeps the sticky flag set.
        if (fault) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            match_cnt_q   <= 4'd0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            revs_q        <= '0;
            err_pulse_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            match_cnt_q   <= match_cnt_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            revs_q        <= revs_d;
            err_pulse_q   <= err_pulse_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign locked      = locked_q;
    assign revs        = revs_q;
    assign err_pulse   = err_pulse_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Table-driven bench for ring_phase_monitor: a left-rotating LOCK_COUNT=4 instance
// and a right-rotating LOCK_COUNT=1 instance, plus an asynchronous reset sequence.
module tb_ring_phase_monitor;

    typedef struct {
        logic       v;
        logic       c;
        logic [3:0] ring;
        logic [1:0] ph;
        logic       pv;
        logic       lk;
        logic [7:0] revs;
        logic       pulse;
        logic       sticky;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ringA = 4'd0,  ringB = 4'd0;
    logic       validA = 1'b0, validB = 1'b0;
    logic       clrA = 1'b0,   clrB = 1'b0;
    logic [1:0] phaseA, phaseB;
    logic       pvA, pvB, lkA, lkB, pulseA, pulseB, stickyA, stickyB;
    logic [7:0] revsA, revsB;

    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t tableA[$];
    vec_t tableB[$];

    always #5 clock = ~clock;

    ring_phase_monitor #(.WIDTH(4), .PH_W(2), .REV_W(8), .LOCK_COUNT(4), .DIR(0)) dutA (
        .clock(clock), .reset(reset), .ring_q(ringA), .ring_valid(validA),
        .err_clr(clrA), .phase(phaseA), .phase_valid(pvA), .locked(lkA),
        .revs(revsA), .err_pulse(pulseA), .err_sticky(stickyA)
    );

    ring_phase_monitor #(.WIDTH(4), .PH_W(2), .REV_W(8), .LOCK_COUNT(1), .DIR(1)) dutB (
        .clock(clock), .reset(reset), .ring_q(ringB), .ring_valid(validB),
        .err_clr(clrB), .phase(phaseB), .phase_valid(pvB), .locked(lkB),
        .revs(revsB), .err_pulse(pulseB), .err_sticky(stickyB)
    );

    function automatic vec_t mk(input logic v, input logic c, input logic [3:0] ring,
                                input logic [1:0] ph, input logic pv, input logic lk,
                                input logic [7:0] revs, input logic pulse, input logic sticky);
        vec_t r;
        r.v = v; r.c = c; r.ring = ring; r.ph = ph; r.pv = pv; r.lk = lk;
        r.revs = revs; r.pulse = pulse; r.sticky = sticky;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t vec, input bit useB, input int idx);
        @(negedge clock);
        if (useB) begin
            validB = vec.v; clrB = vec.c; ringB = vec.ring;
        end else begin
            validA = vec.v; clrA = vec.c; ringA = vec.ring;
        end
        @(posedge clock);
        #1;
        if (useB) begin
            checkOutput("B.phase",  idx, 32'(phaseB),  32'(vec.ph));
            checkOutput("B.pvalid", idx, 32'(pvB),     32'(vec.pv));
            checkOutput("B.locked", idx, 32'(lkB),     32'(vec.lk));
            checkOutput("B.revs",   idx, 32'(revsB),   32'(vec.revs));
            checkOutput("B.pulse",  idx, 32'(pulseB),  32'(vec.pulse));
            checkOutput("B.sticky", idx, 32'(stickyB), 32'(vec.sticky));
        end else begin
            checkOutput("A.phase",  idx, 32'(phaseA),  32'(vec.ph));
            checkOutput("A.pvalid", idx, 32'(pvA),     32'(vec.pv));
            checkOutput("A.locked", idx, 32'(lkA),     32'(vec.lk));
            checkOutput("A.revs",   idx, 32'(revsA),   32'(vec.revs));
            checkOutput("A.pulse",  idx, 32'(pulseA),  32'(vec.pulse));
            checkOutput("A.sticky", idx, 32'(stickyA), 32'(vec.sticky));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".A.phase"},  0, 32'(phaseA),  0);
        checkOutput({tag, ".A.pvalid"}, 0, 32'(pvA),     0);
        checkOutput({tag, ".A.locked"}, 0, 32'(lkA),     0);
        checkOutput({tag, ".A.revs"},   0, 32'(revsA),   0);
        checkOutput({tag, ".A.pulse"},  0, 32'(pulseA),  0);
        checkOutput({tag, ".A.sticky"}, 0, 32'(stickyA), 0);
        checkOutput({tag, ".B.locked"}, 0, 32'(lkB),     0);
        checkOutput({tag, ".B.revs"},   0, 32'(revsB),   0);
    endtask

    initial begin
        // Left rotation, lock after four good steps
        tableA.push_back(mk(1,0,4'b0001, 0,1,0,0, 0,0));
        tableA.push_back(mk(1,0,4'b0010, 1,1,0,0, 0,0));
        tableA.push_back(mk(1,0,4'b0100, 2,1,0,0, 0,0));
        tableA.push_back(mk(1,0,4'b1000, 3,1,0,0, 0,0));
        tableA.push_back(mk(1,0,4'b0001, 0,1,1,0, 0,0));
        for (int r = 1; r <= 2; r++) begin
            tableA.push_back(mk(1,0,4'b0010, 1,1,1,8'(r-1), 0,0));
            tableA.push_back(mk(1,0,4'b0100, 2,1,1,8'(r-1), 0,0));
            tableA.push_back(mk(1,0,4'b1000, 3,1,1,8'(r-1), 0,0));
            tableA.push_back(mk(1,0,4'b0001, 0,1,1,8'(r),   0,0));
        end
        // Skipped step while locked, then reacquire
        tableA.push_back(mk(1,0,4'b0100, 2,1,0,2, 1,1));
        tableA.push_back(mk(1,0,4'b1000, 3,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0001, 0,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0010, 1,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0100, 2,1,1,2, 0,1));
        // Non-one-hot words: single fault pulse, then IDLE and silent reacquire
        tableA.push_back(mk(1,0,4'b0110, 2,0,0,2, 1,1));
        tableA.push_back(mk(1,0,4'b0000, 2,0,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0001, 0,1,0,2, 0,1));
        // ring_valid low holds everything; err_clr alone clears sticky
        tableA.push_back(mk(0,0,4'b0101, 0,1,0,2, 0,1));
        tableA.push_back(mk(0,0,4'b1111, 0,1,0,2, 0,1));
        tableA.push_back(mk(0,0,4'b0010, 0,1,0,2, 0,1));
        tableA.push_back(mk(0,1,4'b0000, 0,1,0,2, 0,0));
        tableA.push_back(mk(1,0,4'b0010, 1,1,0,2, 0,0));
        tableA.push_back(mk(1,0,4'b0100, 2,1,0,2, 0,0));
        tableA.push_back(mk(1,0,4'b1000, 3,1,0,2, 0,0));
        tableA.push_back(mk(1,0,4'b0001, 0,1,1,2, 0,0));
        // err_clr together with a fault: fault wins; pulse drops with valid low
        tableA.push_back(mk(1,1,4'b1000, 3,1,0,2, 1,1));
        tableA.push_back(mk(0,0,4'b1000, 3,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0001, 0,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0010, 1,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b0100, 2,1,0,2, 0,1));
        tableA.push_back(mk(1,0,4'b1000, 3,1,1,2, 0,1));
        for (int r = 3; r <= 5; r++) begin
            tableA.push_back(mk(1,0,4'b0001, 0,1,1,8'(r),   0,1));
            if (r < 5) begin
                tableA.push_back(mk(1,0,4'b0010, 1,1,1,8'(r), 0,1));
                tableA.push_back(mk(1,0,4'b0100, 2,1,1,8'(r), 0,1));
                tableA.push_back(mk(1,0,4'b1000, 3,1,1,8'(r), 0,1));
            end
        end

        // Right rotation with LOCK_COUNT=1: first good step locks
        tableB.push_back(mk(1,0,4'b1000, 3,1,0,0, 0,0));
        tableB.push_back(mk(1,0,4'b0100, 2,1,1,0, 0,0));
        tableB.push_back(mk(1,0,4'b0010, 1,1,1,0, 0,0));
        tableB.push_back(mk(1,0,4'b0001, 0,1,1,0, 0,0));
        tableB.push_back(mk(1,0,4'b1000, 3,1,1,1, 0,0));
        tableB.push_back(mk(1,0,4'b0010, 1,1,0,1, 1,1));
        tableB.push_back(mk(0,0,4'b0010, 1,1,0,1, 0,1));

        #12;
        checkAllZero("reset");
        @(negedge clock);
        reset = 1'b1;

        foreach (tableA[i]) applyStimulus(tableA[i], 1'b0, i);

        // Asynchronous reset mid-cycle while locked with revs=5
        checkOutput("pre.A.revs", 0, 32'(revsA), 5);
        #3;
        reset = 1'b0;
        #1;
        checkAllZero("async");
        @(negedge clock);
        validA = 1'b0;
        reset = 1'b1;

        foreach (tableB[i]) applyStimulus(tableB[i], 1'b1, i);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the 4-bit one-hot ring counter output `q`.
- Samples the ring word and checks that it is one-hot.
- Checks that each sample is the single-step rotation of the previous one.
- Decodes the hot-bit position to a binary phase index.
- Locks after a run of correct steps and counts full revolutions.
- Flags sequence faults.

Used by the scan and timing logic that needs a trusted phase number instead of raw ring bits.

Parameters:
WIDTH, 4, ring width in bits (one-hot word width).
PH_W, 2, phase index width, equal to clog2(WIDTH).
REV_W, 8, revolution counter width.
LOCK_COUNT, 4, consecutive correct transitions required to assert `locked` (range 1..15).
DIR, 0, expected rotation direction. 0 = left (0001->0010->0100->1000->0001). 1 = right (1000->0100->0010->0001->1000).

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset; all state cleared while low.
ring_q  input  WIDTH  ring counter output word.
ring_valid  input  1  ring_q is sampled on this edge when high.
err_clr  input  1  synchronous clear of err_sticky.
phase  output  PH_W  index of the hot bit of the last accepted sample.
phase_valid  output  1  last accepted sample was one-hot.
locked  output  1  sequence verified.
revs  output  REV_W  completed revolutions while locked, modulo 2^REV_W.
err_pulse  output  1  one-cycle strobe on a sequence fault.
err_sticky  output  1  latched fault indicator.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; prev and match_cnt go to 0.
  - All outputs go to 0 immediately and are held until the first rising edge after reset returns high.
- All outputs are registered. A sample accepted on edge k is reflected in the outputs after edge k (1-cycle latency).
- ring_valid=0: nothing changes (state, prev, outputs held), except that err_pulse returns to 0 and err_clr still acts.
- Definitions:
  - onehot = exactly one bit of ring_q set.
  - exp = prev rotated by one position in direction DIR.
  - good = onehot and ring_q == exp.
- States (on each edge with ring_valid=1):
  - IDLE:
    - onehot: prev<=ring_q, match_cnt<=0, go to ACQUIRE.
    - otherwise: stay in IDLE.
  - ACQUIRE:
    - good: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1.
    - onehot but not good: prev<=ring_q, match_cnt<=0, stay in ACQUIRE, no error.
    - not onehot: go to IDLE, no error.
  - LOCKED:
    - good: stay in LOCKED. If the phase goes from WIDTH-1 to 0 (DIR=0), or from 0 to WIDTH-1 (DIR=1), then revs<=revs+1 with wrap.
    - not good: err_pulse=1 for one cycle, err_sticky<=1, locked<=0.
      - If onehot: go to ACQUIRE with prev<=ring_q, match_cnt<=0.
      - Otherwise: go to IDLE.
- prev updates on every accepted sample.
- phase/phase_valid update on every accepted sample:
  - onehot: phase = index of the set bit, phase_valid=1.
  - not onehot: phase holds its previous value, phase_valid=0.
- revs is held, not cleared, when lock is lost. It is cleared only by reset.
- err_clr clears err_sticky. If err_clr and a new fault occur on the same edge, the fault wins and err_sticky stays 1.
- Faults are detected only in LOCKED. Faults during IDLE or ACQUIRE never set err_pulse or err_sticky.
- With LOCK_COUNT=1, the first good transition after IDLE->ACQUIRE locks.

Test Plan:
1. Reset low, then DIR=0 sequence 0001,0010,0100,1000,0001, ring_valid=1 every cycle -> phase 0,1,2,3,0; locked rises after the 5th edge; err_sticky stays 0; revs=0 (the 3->0 step occurs before lock).
2. Continue from locked for 8 more steps (0010..0001 twice) -> revs=2, each increment on the edge accepting 0001 after 1000; locked stays 1.
3. While locked, expect 0010 but drive 0100 -> err_pulse=1 for exactly one cycle, err_sticky=1, locked=0, phase=2. Then drive 1000,0001,0010,0100 -> locked=1 again after the 4th edge.
4. While locked, drive 0110 then 0000 -> err_pulse once (only the first bad sample), phase_valid=0, state IDLE; the next 0001 enters ACQUIRE without an error.
5. Hold ring_valid=0 for 3 cycles while the ring_q input changes -> all outputs unchanged. Assert err_clr alone -> err_sticky=0. Assert err_clr on the same edge as a fault -> err_sticky=1.
6. Pull reset low asynchronously mid-cycle while locked with revs=5 -> locked, revs, phase, err_sticky all 0 immediately, before the next clock edge.
